mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (i_*) and the load/store requester (d_*).
- The d_* side carries the byte-lane strobes and replicated store data produced by the EX-stage store formatter.
- Allows one outstanding transaction at a time. Sits between the CPU core and the cache/bus bridge.
- Data side has priority, with a one-turn anti-starvation rule for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock, asynchronous, active-low
i_req  in  1  fetch request, held until i_addr_ok
i_addr  in  ADDR_W  fetch address
i_addr_ok  out  1  fetch address accepted (1-cycle pulse)
i_data_ok  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  DATA_W  fetch read data
d_req  in  1  load/store request, held until d_addr_ok
d_wr  in  1  1 = store
d_size  in  2  0 byte, 1 half, 2 word
d_addr  in  ADDR_W  data address
d_wstrb  in  DATA_W/8  byte-lane strobes
d_wdata  in  DATA_W  store data, already lane-replicated
d_addr_ok  out  1  data address accepted
d_data_ok  out  1  load data valid or store complete
d_rdata  out  DATA_W  load read data
m_req  out  1  downstream request
m_wr  out  1  downstream write
m_size  out  2  downstream size
m_addr  out  ADDR_W  downstream address
m_wstrb  out  DATA_W/8  downstream strobes
m_wdata  out  DATA_W  downstream write data
m_addr_ok  in  1  downstream address handshake
m_data_ok  in  1  downstream data handshake
m_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, owner=NONE, last_data=0.
  - All m_* registers cleared to 0, so m_req=0.
  - All *_addr_ok and *_data_ok outputs = 0.
  - Reset mid-transaction abandons it; any late m_data_ok is ignored.
- FSM states: IDLE, ADDR, WAIT.
- IDLE, grant selection:
  - Grant D if d_req and not (last_data and i_req).
  - Otherwise grant I if i_req.
  - Otherwise stay in IDLE.
  - On grant, latch the winner's request fields into the m_* registers and set owner.
    - I fields: m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
  - Set last_data = (owner==D).
  - Next state = ADDR.
  - IDLE to m_req is 1 cycle of latency.
- ADDR:
  - m_req=1; m_* fields stay stable until accepted.
  - Owner's addr_ok = m_addr_ok, combinational; the non-owner sees 0.
  - On m_addr_ok go to WAIT. m_req drops the next cycle.
  - m_data_ok is ignored in ADDR.
- WAIT:
  - m_req=0.
  - Owner's data_ok = m_data_ok and owner's rdata = m_rdata, combinational.
  - On m_data_ok go to IDLE; owner becomes NONE.
  - Re-arbitration happens in that IDLE cycle. Minimum turnaround is 1 idle cycle between transactions.
- Stores: d_data_ok still pulses once; d_rdata is don't-care.
- Non-owner requester's req stays pending, with no addr_ok, until granted.
- d_wstrb = 0 with d_wr=1 is forwarded unchanged (a misaligned store is squashed upstream). The arbiter does no alignment checks.
- Starvation bound: with both sides requesting continuously, grants alternate D, I, D, I…
- rdata outputs to the non-owner are held at 0.

Decomposition:
- Shared package: state encodings (IDLE/ADDR/WAIT), owner codes (NONE/I/D), size codes (BYTE/HALF/WORD).
- Sub-module mem_arb_pick: combinational 2-way priority picker with inputs i_req, d_req, last_data and outputs grant_i, grant_d.
- The FSM and request registers stay in the top module.

Test Plan:
1. Only i_req, i_addr=0xBFC00000.
   - Required: m_req=1 next cycle, m_addr=0xBFC00000, m_wr=0, m_size=2, m_wstrb=0.
   - Drive m_addr_ok → i_addr_ok pulses in the same cycle.
   - Drive m_data_ok with m_rdata=0x24080001 → i_data_ok=1, i_rdata=0x24080001.
2. i_req and d_req in the same cycle; d store addr=0x80000002, wstrb=4'b1100, wdata=0xBEEFBEEF.
   - Required: D granted first with m_wstrb=1100, m_wdata=0xBEEFBEEF.
   - After D's data_ok plus 1 idle cycle, I is granted.
3. Both requesting continuously for 6 transactions.
   - Required: grant order D, I, D, I, D, I; neither addr_ok pulses for the non-owner.
4. m_addr_ok held low for 5 cycles.
   - Required: m_req and all m_* fields remain stable for those 5 cycles.
   - Required: no addr_ok to any requester until m_addr_ok=1.
5. m_data_ok asserted while in ADDR (spurious).
   - Required: ignored, no data_ok out, state stays ADDR.
6. resetn pulled low during WAIT, released, then m_data_ok asserted.
   - Required: all outputs go 0 immediately, state=IDLE, and no data_ok is forwarded to either requester.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, load/store port and the shared downstream port.
// slave = the arbiter's view; master = the core + memory side driving it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [STRB_W-1:0] m_wstrb;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way grant picker: data wins unless it won last time and fetch is waiting.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_data,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & ~(last_data & i_req);
  assign grant_i = i_req & ~grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one transaction in flight.
// Arbitrates in IDLE, presents the latched request in ADDR, waits for data in WAIT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus
);

  localparam int STRB_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              last_data_q, last_data_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [1:0]        m_size_q, m_size_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  logic pick_i, pick_d;

  mem_arb_pick u_pick (
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .last_data (last_data_q),
    .grant_i   (pick_i),
    .grant_d   (pick_d)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_data_d = last_data_q;
    m_req_d     = m_req_q;
    m_wr_d      = m_wr_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wstrb_d   = m_wstrb_q;
    m_wdata_d   = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_D;
          last_data_d = 1'b1;
          m_req_d     = 1'b1;
          m_wr_d      = bus.d_wr;
          m_size_d    = bus.d_size;
          m_addr_d    = bus.d_addr;
          m_wstrb_d   = bus.d_wstrb;
          m_wdata_d   = bus.d_wdata;
        end else if (pick_i) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_I;
          last_data_d = 1'b0;
          m_req_d     = 1'b1;
          m_wr_d      = 1'b0;
          m_size_d    = SZ_WORD;
          m_addr_d    = bus.i_addr;
          m_wstrb_d   = '0;
          m_wdata_d   = '0;
        end
      end
      ST_ADDR: begin
        // m_data_ok here is a protocol violation downstream and is dropped
        if (bus.m_addr_ok) begin
          state_d = ST_WAIT;
          m_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.m_data_ok) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      last_data_q <= 1'b0;
      m_req_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_size_q    <= '0;
      m_addr_q    <= '0;
      m_wstrb_q   <= '0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_data_q <= last_data_d;
      m_req_q     <= m_req_d;
      m_wr_q      <= m_wr_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wstrb_q   <= m_wstrb_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  logic in_addr, in_wait, own_i, own_d;
  assign in_addr = (state_q == ST_ADDR);
  assign in_wait = (state_q == ST_WAIT);
  assign own_i   = (owner_q == OWN_I);
  assign own_d   = (owner_q == OWN_D);

  assign bus.m_req   = m_req_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_size  = m_size_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.m_wdata = m_wdata_q;

  // Handshakes pass straight through to the owner only; the loser sees nothing
  assign bus.i_addr_ok = in_addr & own_i & bus.m_addr_ok;
  assign bus.d_addr_ok = in_addr & own_d & bus.m_addr_ok;
  assign bus.i_data_ok = in_wait & own_i & bus.m_data_ok;
  assign bus.d_data_ok = in_wait & own_d & bus.m_data_ok;
  assign bus.i_rdata   = (in_wait & own_i) ? bus.m_rdata : '0;
  assign bus.d_rdata   = (in_wait & own_d) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level bench: requesters and memory are modelled here, grants are
// predicted from the priority rule (data first, fetch gets every other turn).
module tb_mem_port_arbiter;

  typedef struct {
    logic        vld;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  req_t ip, dp;
  bit   last_d;   // model: previous grant went to data
  bit   obs_d;    // which side the DUT actually acknowledged last

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t rnd_i();
    req_t r;
    r.vld = 1'b1; r.wr = 1'b0; r.size = 2'd2;
    r.addr = {$urandom_range(32'h3fff_ffff), 2'b00};
    r.wstrb = 4'($urandom_range(15)); r.wdata = $urandom;
    return r;
  endfunction

  function automatic req_t rnd_d();
    req_t r;
    r.vld = 1'b1; r.wr = 1'($urandom_range(1));
    r.size = 2'($urandom_range(2));
    r.addr = $urandom; r.wstrb = 4'($urandom_range(15)); r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rd);
    bus.i_req   = ip.vld;  bus.i_addr = ip.addr;
    bus.d_req   = dp.vld;  bus.d_wr   = dp.wr;   bus.d_size  = dp.size;
    bus.d_addr  = dp.addr; bus.d_wstrb = dp.wstrb; bus.d_wdata = dp.wdata;
    bus.m_addr_ok = aok; bus.m_data_ok = dok; bus.m_rdata = rd;
  endtask

  task automatic maybe_new();
    if (!ip.vld && $urandom_range(2) == 0) ip = rnd_i();
    if (!dp.vld && $urandom_range(2) == 0) dp = rnd_d();
  endtask

  // One full transaction starting from an idle DUT: grant cycle, address phase
  // with astall wait cycles, data phase with dstall wait cycles.
  task automatic do_txn(input int astall, input int dstall, input bit spur,
                        input logic [31:0] rd, input bit rnd_new);
    bit   win_d;
    req_t w;
    logic [31:0] rv;
    logic dok;
    if (!ip.vld && !dp.vld) begin
      if ($urandom_range(1) == 1) ip = rnd_i(); else dp = rnd_d();
    end
    @(negedge clk); drive_bus(1'b0, 1'b0, $urandom); #1;
    chk("idle_mreq", bus.m_req, 0);
    chk("idle_aok", {bus.i_addr_ok, bus.d_addr_ok}, 0);
    chk("idle_dok", {bus.i_data_ok, bus.d_data_ok}, 0);
    win_d  = dp.vld && !(last_d && ip.vld);
    last_d = win_d;
    w = win_d ? dp : ip;
    if (!win_d) begin w.wr = 1'b0; w.size = 2'd2; w.wstrb = '0; w.wdata = '0; end

    for (int c = 0; c <= astall; c++) begin
      @(negedge clk);
      if (rnd_new) maybe_new();
      dok = spur ? 1'($urandom_range(1)) : 1'b0;
      if (spur && c == 0) dok = 1'b1;
      drive_bus(c == astall, dok, $urandom); #1;
      chk("a_mreq", bus.m_req, 1);
      chk("a_mwr", bus.m_wr, w.wr);
      chk("a_msize", bus.m_size, w.size);
      chk("a_maddr", bus.m_addr, w.addr);
      chk("a_mwstrb", bus.m_wstrb, w.wstrb);
      chk("a_mwdata", bus.m_wdata, w.wdata);
      chk("a_iaok", bus.i_addr_ok, (c == astall) && !win_d);
      chk("a_daok", bus.d_addr_ok, (c == astall) && win_d);
      chk("a_dok", {bus.i_data_ok, bus.d_data_ok}, 0);
      chk("a_nonown_rdata", win_d ? bus.i_rdata : bus.d_rdata, 0);
      if (c == astall) obs_d = bus.d_addr_ok;
    end
    if (win_d) dp.vld = 1'b0; else ip.vld = 1'b0;

    for (int c = 0; c <= dstall; c++) begin
      @(negedge clk);
      if (rnd_new) maybe_new();
      rv = (c == dstall) ? rd : $urandom;
      drive_bus(1'b0, c == dstall, rv); #1;
      chk("w_mreq", bus.m_req, 0);
      chk("w_aok", {bus.i_addr_ok, bus.d_addr_ok}, 0);
      chk("w_idok", bus.i_data_ok, (c == dstall) && !win_d);
      chk("w_ddok", bus.d_data_ok, (c == dstall) && win_d);
      chk("w_nonown_rdata", win_d ? bus.i_rdata : bus.d_rdata, 0);
      if (!win_d) chk("w_irdata", bus.i_rdata, rv);
      else if (!w.wr) chk("w_drdata", bus.d_rdata, rv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ip = '{default: '0}; dp = '{default: '0};
    last_d = 1'b0; obs_d = 1'b0;
    drive_bus(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mreq", bus.m_req, 0);
    chk("rst_maddr", bus.m_addr, 0);
    chk("rst_ok", {bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok}, 0);
    @(negedge clk); resetn = 1'b1;

    // 1: fetch only, boot address
    ip = rnd_i(); ip.addr = 32'hBFC0_0000;
    do_txn(0, 0, 1'b0, 32'h2408_0001, 1'b0);
    chk("t1_owner", obs_d, 0);

    // 2: simultaneous requests, data store wins, fetch follows after one idle cycle
    ip = rnd_i();
    dp = '{vld: 1'b1, wr: 1'b1, size: 2'd1, addr: 32'h8000_0002,
           wstrb: 4'b1100, wdata: 32'hBEEF_BEEF};
    do_txn(0, 1, 1'b0, $urandom, 1'b0);
    chk("t2_first_d", obs_d, 1);
    do_txn(0, 0, 1'b0, $urandom, 1'b0);
    chk("t2_then_i", obs_d, 0);

    // 3: both requesting continuously -> strict alternation
    for (int k = 0; k < 6; k++) begin
      if (!ip.vld) ip = rnd_i();
      if (!dp.vld) dp = rnd_d();
      do_txn(k % 2, 1, 1'b0, $urandom, 1'b0);
      chk("t3_alt", obs_d, (k % 2) == 0);
    end

    // 4: long address stall, fields must hold
    ip = rnd_i(); dp.vld = 1'b0;
    do_txn(5, 0, 1'b0, $urandom, 1'b0);

    // 5: spurious data handshake during the address phase
    dp = rnd_d(); dp.wr = 1'b0;
    do_txn(3, 2, 1'b1, $urandom, 1'b0);

    // 6: reset during WAIT of a data transaction; late m_data_ok must be dropped
    ip.vld = 1'b0; dp = rnd_d();
    @(negedge clk); drive_bus(1'b0, 1'b0, '0);
    @(negedge clk); drive_bus(1'b1, 1'b0, '0); #1;
    chk("t6_daok", bus.d_addr_ok, 1);
    dp.vld = 1'b0;
    @(negedge clk); drive_bus(1'b0, 1'b0, '0); #1;
    chk("t6_wait_mreq", bus.m_req, 0);
    @(negedge clk);
    ip = rnd_i(); dp = rnd_d();
    resetn = 1'b0;
    drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF); #1;
    chk("t6_rst_mreq", bus.m_req, 0);
    chk("t6_rst_mfields", {bus.m_wr, bus.m_size, bus.m_wstrb}, 0);
    chk("t6_rst_maddr", bus.m_addr, 0);
    chk("t6_rst_mwdata", bus.m_wdata, 0);
    chk("t6_rst_ok", {bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok}, 0);
    chk("t6_rst_rdata", bus.d_rdata | bus.i_rdata, 0);
    ip.vld = 1'b0; dp.vld = 1'b0;
    @(negedge clk); resetn = 1'b1;
    drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF); #1;
    chk("t6_late_dok", {bus.i_data_ok, bus.d_data_ok}, 0);
    chk("t6_late_mreq", bus.m_req, 0);
    last_d = 1'b0;
    // last_data was 1 before reset; cleared, data must win again
    ip = rnd_i(); dp = rnd_d();
    do_txn(0, 0, 1'b0, $urandom, 1'b0);
    chk("t6_post_d", obs_d, 1);

    // randomized traffic
    for (int k = 0; k < 60; k++)
      do_txn($urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
             $urandom, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
